// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the IF/ID record exchanged between the fetch
// and decode stages.
package cpu_pkg;

  localparam int              PC_W      = 10;
  localparam int              INSTR_W   = 32;
  localparam logic [PC_W-1:0] RESET_PC  = '0;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;
  localparam int              PC_INC    = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures pc/instr on a normal fetch, holds on stall,
// and inserts a NOP bubble on flush.
module if_id_reg #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      // The squashed slot still records the pc it replaced.
      if_id_pc    <= pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc;
      if_id_instr <= instr;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 incrementer, alignment check,
// fetch counter and the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 PC_W      = cpu_pkg::PC_W,
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               align_err,
  output logic [CNT_W-1:0]   fetch_count
);

  logic pc_load;
  logic fetch;

  // Flush overrides stall so a branch redirect is never lost.
  assign pc_load  = flush || !stall;
  assign fetch    = !flush && !stall;
  assign pc_plus4 = pc + PC_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      align_err <= pc_load && (next_pc[1:0] != 2'b00);
      if (pc_load) begin
        pc <= {next_pc[PC_W-1:2], 2'b00};
      end
      if (fetch && (fetch_count != {CNT_W{1'b1}})) begin
        fetch_count <= fetch_count + 1'b1;
      end
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .pc          (pc),
    .instr       (instr_in),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

  logic               clk;
  logic               rst_n;
  logic [PC_W-1:0]    next_pc;
  logic               stall;
  logic               flush;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;
  logic               align_err;
  logic [CNT_W-1:0]   fetch_count;

  logic               tie;
  logic [PC_W-1:0]    forced_pc;
  int                 checks;
  int                 failures;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .stall       (stall),
    .flush       (flush),
    .instr_in    (instr_in),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .align_err   (align_err),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model and PC-select mux.
  always_comb begin
    instr_in = 32'hA000_0000 | {22'd0, pc};
    next_pc  = tie ? pc_plus4 : forced_pc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    tie = 1'b1; forced_pc = '0; stall = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    cmp("rst_pc", 32'(pc), 32'h0);
    cmp("rst_pc_plus4", 32'(pc_plus4), 32'h4);
    cmp("rst_valid", 32'(if_id_valid), 32'h0);
    cmp("rst_instr", if_id_instr, 32'h0);
    cmp("rst_count", 32'(fetch_count), 32'h0);
    step();
    cmp("first_pc", 32'(pc), 32'h4);
    cmp("first_if_id_pc", 32'(if_id_pc), 32'h0);
    cmp("first_valid", 32'(if_id_valid), 32'h1);
    cmp("first_count", 32'(fetch_count), 32'h1);
  endtask

  task automatic test_sequential();
    for (int i = 2; i <= 5; i++) begin
      step();
      cmp("seq_pc", 32'(pc), 32'(i * 4));
      cmp("seq_if_id_pc", 32'(if_id_pc), 32'((i - 1) * 4));
      cmp("seq_instr", if_id_instr, 32'hA000_0000 | 32'((i - 1) * 4));
      cmp("seq_count", 32'(fetch_count), 32'(i));
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step();
    step();
    cmp("pre_stall_pc", 32'(pc), 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("stall_pc", 32'(pc), 32'h8);
      cmp("stall_if_id_pc", 32'(if_id_pc), 32'h4);
      cmp("stall_instr", if_id_instr, 32'hA000_0004);
      cmp("stall_count", 32'(fetch_count), 32'h2);
    end
    stall = 1'b0;
    step();
    cmp("post_stall_pc", 32'(pc), 32'hC);
    cmp("post_stall_if_id_pc", 32'(if_id_pc), 32'h8);
    cmp("post_stall_count", 32'(fetch_count), 32'h3);
  endtask

  task automatic test_flush();
    tie = 1'b0; forced_pc = 10'h100;
    stall = 1'b1; flush = 1'b1;
    step();
    cmp("flush_pc", 32'(pc), 32'h100);
    cmp("flush_valid", 32'(if_id_valid), 32'h0);
    cmp("flush_instr", if_id_instr, 32'h0);
    cmp("flush_if_id_pc", 32'(if_id_pc), 32'hC);
    cmp("flush_count", 32'(fetch_count), 32'h3);
    cmp("flush_align", 32'(align_err), 32'h0);
    stall = 1'b0; flush = 1'b0; tie = 1'b1;
    step();
    cmp("after_flush_pc", 32'(pc), 32'h104);
    cmp("after_flush_if_id_pc", 32'(if_id_pc), 32'h100);
    cmp("after_flush_instr", if_id_instr, 32'hA000_0100);
    cmp("after_flush_valid", 32'(if_id_valid), 32'h1);
    cmp("after_flush_count", 32'(fetch_count), 32'h4);
  endtask

  task automatic test_wrap_align();
    tie = 1'b0; forced_pc = 10'h3FC;
    step();
    cmp("wrap_pc", 32'(pc), 32'h3FC);
    cmp("wrap_pc_plus4", 32'(pc_plus4), 32'h0);
    tie = 1'b1;
    step();
    cmp("wrap_pc_next", 32'(pc), 32'h0);
    cmp("wrap_align", 32'(align_err), 32'h0);
    tie = 1'b0; forced_pc = 10'h103;
    step();
    cmp("align_pc", 32'(pc), 32'h100);
    cmp("align_err_set", 32'(align_err), 32'h1);
    tie = 1'b1;
    step();
    cmp("align_err_clear", 32'(align_err), 32'h0);
    cmp("align_pc_next", 32'(pc), 32'h104);
    // A misaligned value presented during a stall is not loaded.
    tie = 1'b0; forced_pc = 10'h2A1; stall = 1'b1;
    step();
    cmp("stall_no_align", 32'(align_err), 32'h0);
    cmp("stall_no_load", 32'(pc), 32'h104);
    stall = 1'b0; tie = 1'b1;
  endtask

  task automatic test_async_reset();
    step();
    step();
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_pc", 32'(pc), 32'h0);
    cmp("arst_if_id_pc", 32'(if_id_pc), 32'h0);
    cmp("arst_instr", if_id_instr, 32'h0);
    cmp("arst_valid", 32'(if_id_valid), 32'h0);
    cmp("arst_align", 32'(align_err), 32'h0);
    cmp("arst_count", 32'(fetch_count), 32'h0);
    step();
    stall = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; tie = 1'b1; forced_pc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_wrap_align();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
